inst_sram: RTL and testbench
============================

INST_SRAM -- requirements
Module: inst_sram

Interface
REQ-001 Parameter BASE, default 32'h80000000, byte address of word 0.
REQ-002 Parameter DEPTH, default 4096, number of 32-bit words; power of two.
REQ-003 Parameter LATENCY, default 1, legal range 1..15; sets cycles from request acceptance to rvalid.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port arvalid, input, 1 bit: fetch requester presents a valid address.
REQ-007 Port arready, output, 1 bit: responder can accept a request.
REQ-008 Port araddr, input, 32 bits: fetch byte address (the requester's pc).
REQ-009 Port rvalid, output, 1 bit: response data valid.
REQ-010 Port rready, input, 1 bit: requester accepts the response.
REQ-011 Port rdata, output, 32 bits: instruction word.
REQ-012 Port rresp, output, 2 bits: 2'b00 OKAY, 2'b10 error.
REQ-013 Port ld_en, input, 1 bit: preload write enable.
REQ-014 Port ld_addr, input, 32 bits: preload byte address.
REQ-015 Port ld_data, input, 32 bits: preload word.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-017 The block SHALL drive arready=1 only in IDLE and rvalid=1 only in RESP; both are decoded from registered state.
REQ-018 A request SHALL be accepted on the cycle with arvalid&&arready; araddr is ignored in every other cycle.
REQ-019 On acceptance, the block SHALL read the memory word at index (araddr-BASE)>>2 and register it, together with rresp, in the same edge.
REQ-020 If araddr[1:0]!=0, or araddr<BASE, or araddr>=BASE+4*DEPTH, the block SHALL register rresp=2'b10 and rdata=0 and leave memory untouched.
REQ-021 For an in-range, aligned address, the block SHALL register rresp=2'b00 and the word read.
REQ-022 Transitions SHALL be: IDLE->RESP on acceptance if LATENCY==1; IDLE->BUSY with counter=LATENCY-2 on acceptance if LATENCY>1.
REQ-023 BUSY SHALL decrement the 4-bit counter each cycle and go to RESP on the cycle after the counter reaches 0.
REQ-024 rvalid SHALL first assert exactly LATENCY cycles after the acceptance edge.
REQ-025 In RESP, rdata and rresp SHALL hold stable until rvalid&&rready; then the FSM goes to IDLE, with arready=1 on the next cycle.
REQ-026 In RESP with rready=0, the block SHALL hold indefinitely; there is no timeout.
REQ-027 Maximum throughput SHALL be one request per LATENCY+1 cycles; no request is accepted while one is outstanding.
REQ-028 A preload write with ld_en=1 SHALL write ld_data to word (ld_addr-BASE)>>2 at the clock edge in any state; out-of-range or misaligned ld_addr is dropped silently.
REQ-029 When a preload write and acceptance hit the same word in the same cycle, the response SHALL carry the pre-write (old) word.
REQ-030 A preload write to the word of an outstanding request SHALL NOT alter the registered rdata.
REQ-031 Address arithmetic SHALL be 32-bit unsigned; BASE+4*DEPTH SHALL NOT wrap for legal parameters.

Reset
REQ-032 While rst_n=0, the block SHALL hold state=IDLE, arready=1, rvalid=0, rdata=0, rresp=2'b00, and counter=0, independent of clk.
REQ-033 Reset assertion mid-BUSY or mid-RESP SHALL drop the outstanding response with no rvalid after release.
REQ-034 Memory contents SHALL NOT be initialised by reset.

Verification
REQ-035 Basic fetch: LATENCY=1; preload 0x80000000 with 0x00000413; arvalid with araddr=0x80000000 -> rvalid next cycle, rdata=0x00000413, rresp=00; arready=1 one cycle after rvalid&&rready.
REQ-036 Latency: LATENCY=3; accept at cycle 0 -> rvalid rises at cycle 3, arready=0 in cycles 1-3.
REQ-037 Backpressure: hold rready=0 for 5 cycles in RESP -> rvalid and rdata stable throughout, no new request accepted despite arvalid=1.
REQ-038 Errors: araddr=0x80000002 -> rresp=10, rdata=0; araddr=0x7FFFFFFC -> rresp=10; araddr=BASE+4*DEPTH -> rresp=10.
REQ-039 Collision: ld_en with 0xDEADBEEF to 0x80000010 in the acceptance cycle of 0x80000010 (old 0x11111111) -> rdata=0x11111111; the following fetch returns 0xDEADBEEF.
REQ-040 Async reset: drop rst_n between edges while in BUSY -> rvalid=0 and arready=1 immediately; after release, no stale rvalid.

Source files
------------

// File: rtl/inst_sram.sv
// -----------------------------------------------------------------------------
// inst_sram: instruction memory with a valid/ready fetch port and a preload port.
//
// Ports:
//   clk, rst_n            - single clock, asynchronous active-low reset
//   arvalid/arready/araddr - fetch request handshake and byte address (pc)
//   rvalid/rready         - response handshake
//   rdata, rresp          - instruction word and status (00 OKAY, 10 error)
//   ld_en/ld_addr/ld_data - preload write port, usable in any state
//
// A request is accepted only in IDLE.  The word and status are captured at the
// acceptance edge, then presented LATENCY cycles later and held until taken.
// -----------------------------------------------------------------------------
module inst_sram #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
    // BUSY counts down from LATENCY-2 and leaves one cycle after hitting zero.
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] mem [DEPTH];

    // Aligned and inside [BASE, BASE+4*DEPTH); subtraction only after a>=BASE.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    assign arready = (state_q == IDLE);
    assign rvalid  = (state_q == RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // Preload port; memory is never cleared by reset.  A write landing on the
    // same edge as an acceptance leaves the captured word at its old value.
    always_ff @(posedge clk) begin
        if (ld_en && addr_ok(ld_addr)) begin
            mem[word_idx(ld_addr)] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arvalid) begin
                        if (addr_ok(araddr)) begin
                            rdata_q <= mem[word_idx(araddr)];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= 32'd0;
                            rresp_q <= RESP_ERR;
                        end
                        if (LATENCY > 1) begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_sram.sv
// -----------------------------------------------------------------------------
// tb_inst_sram: two inst_sram instances (LATENCY 1 and 3) sharing clock, reset
// and the preload bus; each has its own fetch port.  A word-array model of the
// memory predicts every response from the address map rules.
// -----------------------------------------------------------------------------
module tb_inst_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] END_A = BASE + 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] araddr  [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic [31:0] model [DEPTH];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_sram #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
        .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_sram #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
        .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_map(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < END_A);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (in_map(a)) model[int'((a - BASE) >> 2)] = d;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_rvalid"}, 32'(rvalid[d]), 32'd0);
        check({tag, "_arready"}, 32'(arready[d]), 32'd1);
    endtask

    // One fetch on port d; hold = cycles of rready=0 backpressure in RESP,
    // col = preload write issued in the acceptance cycle.
    task automatic fetch(input int d, input logic [31:0] a, input int hold,
                         input bit col, input logic [31:0] col_a, input logic [31:0] col_d);
        logic [31:0] ed;
        logic [1:0]  er;
        int          lat;
        lat = (d == 0) ? 1 : 3;
        if (in_map(a)) begin
            ed = model[int'((a - BASE) >> 2)];
            er = 2'b00;
        end else begin
            ed = 32'd0;
            er = 2'b10;
        end
        @(negedge clk);
        check("arready_before", 32'(arready[d]), 32'd1);
        arvalid[d] = 1'b1; araddr[d] = a; rready[d] = 1'b0;
        if (col) begin
            ld_en = 1'b1; ld_addr = col_a; ld_data = col_d;
        end
        @(negedge clk);
        arvalid[d] = 1'b0; araddr[d] = $urandom; ld_en = 1'b0;
        if (col) model_write(col_a, col_d);
        for (int k = 1; k < lat; k++) begin
            check("rvalid_early", 32'(rvalid[d]), 32'd0);
            check("arready_busy", 32'(arready[d]), 32'd0);
            @(negedge clk);
        end
        check("rvalid_resp", 32'(rvalid[d]), 32'd1);
        check("arready_resp", 32'(arready[d]), 32'd0);
        check("rdata", rdata[d], ed);
        check("rresp", 32'(rresp[d]), 32'(er));
        for (int h = 0; h < hold; h++) begin
            arvalid[d] = 1'b1; araddr[d] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            ld_en = 1'b1; ld_data = $urandom;
            ld_addr = ($urandom_range(0, 1) == 1) ? a : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            @(negedge clk);
            model_write(ld_addr, ld_data);
            ld_en = 1'b0; arvalid[d] = 1'b0;
            check("hold_rvalid", 32'(rvalid[d]), 32'd1);
            check("hold_arready", 32'(arready[d]), 32'd0);
            check("hold_rdata", rdata[d], ed);
            check("hold_rresp", 32'(rresp[d]), 32'(er));
        end
        rready[d] = 1'b1;
        @(negedge clk);
        rready[d] = 1'b0;
        check_idle(d, "after_hs");
    endtask

    initial begin
        logic [31:0] a;
        int d, kind, idx;
        for (int i = 0; i < 2; i++) begin
            arvalid[i] = 1'b0; araddr[i] = 32'd0; rready[i] = 1'b0;
        end
        ld_en = 1'b0; ld_addr = 32'd0; ld_data = 32'd0;

        // Reset values, checked while rst_n is low
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_idle(i, "reset");
            check("reset_rdata", rdata[i], 32'd0);
            check("reset_rresp", 32'(rresp[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Preload every word, then the directed words
        for (int i = 0; i < DEPTH; i++) load(BASE + 32'(4 * i), $urandom);
        load(32'h8000_0000, 32'h0000_0413);
        load(32'h8000_0010, 32'h1111_1111);
        load(32'h8000_0001, 32'hBAD0_BAD0);   // misaligned: dropped
        load(END_A, 32'hBAD1_BAD1);           // out of range: dropped

        // Basic fetch, latency 1
        fetch(0, 32'h8000_0000, 0, 1'b0, 32'd0, 32'd0);
        // Latency 3, then backpressure for 5 cycles
        fetch(1, 32'h8000_0000, 0, 1'b0, 32'd0, 32'd0);
        fetch(1, 32'h8000_0004, 5, 1'b0, 32'd0, 32'd0);
        fetch(0, 32'h8000_0008, 5, 1'b0, 32'd0, 32'd0);

        // Error responses on both ports
        for (int i = 0; i < 2; i++) begin
            fetch(i, 32'h8000_0002, 0, 1'b0, 32'd0, 32'd0);
            fetch(i, 32'h7FFF_FFFC, 0, 1'b0, 32'd0, 32'd0);
            fetch(i, END_A, 0, 1'b0, 32'd0, 32'd0);
        end

        // Collision: preload the same word in the acceptance cycle
        fetch(0, 32'h8000_0010, 0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        fetch(0, 32'h8000_0010, 0, 1'b0, 32'd0, 32'd0);
        check("collision_model", model[4], 32'hDEAD_BEEF);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        arvalid[1] = 1'b1; araddr[1] = BASE + 32'd8; rready[1] = 1'b1;
        @(negedge clk);
        arvalid[1] = 1'b0;
        check("busy_arready", 32'(arready[1]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_idle(1, "async_rst");
        check("async_rst_rdata", rdata[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_idle(1, "post_rst");
        end
        rready[1] = 1'b0;

        // Randomized fetches
        for (int n = 0; n < 30; n++) begin
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, DEPTH - 1);
            case (kind)
                0:       a = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
                1:       a = BASE - 32'(4 * $urandom_range(1, 8));
                2:       a = END_A + 32'(4 * $urandom_range(0, 8));
                default: a = BASE + 32'(4 * idx);
            endcase
            fetch(d, a, $urandom_range(0, 3), kind >= 7, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
